program_loader: RTL and testbench

Boot-time program loader upstream of the 8-bit accumulator CPU. It accepts a framed byte stream over a valid/ready handshake and writes it into program memory starting at address 0. It checks an 8-bit checksum and releases the CPU by asserting `cpu_run` only after a clean load. While `cpu_run` is low, the system top routes the loader's memory-write port into program memory instead of the CPU's address mux and write strobe.

---
 rtl/program_loader_pkg.sv | 24 ++
 rtl/program_loader.sv | 118 +++++++++++
 tb/tb_program_loader.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_pkg.sv
// Shared types and width helpers for the boot-time program loader.
package program_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CHECK = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } ld_state_t;

    localparam int DEF_WIDTH_REG = 8;
    localparam int DEF_OPCODE    = 3;

    function automatic int calc_aw(input int width_reg, input int opcode);
        return width_reg - opcode;
    endfunction

    // Checksum is taken modulo 2^width of the data path.
    function automatic int csum_w(input int width_reg);
        return width_reg;
    endfunction

endpackage

// File: rtl/program_loader.sv
// Framed byte-stream loader: header, data bytes, checksum; writes program
// memory from address 0 and releases the CPU only after a clean load.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int WIDTH_REG = DEF_WIDTH_REG,
    parameter int OPCODE    = DEF_OPCODE,
    localparam int AW       = calc_aw(WIDTH_REG, OPCODE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [WIDTH_REG-1:0] in_data,
    output logic                 in_ready,
    input  logic                 reload,
    output logic                 mem_wr,
    output logic [AW-1:0]        mem_addr,
    output logic [WIDTH_REG-1:0] mem_data,
    output logic                 cpu_run,
    output logic                 done,
    output logic                 error
);

    localparam int SW = csum_w(WIDTH_REG);

    ld_state_t          r_state;
    ld_state_t          w_next;
    logic [AW-1:0]      r_cnt;
    logic [AW-1:0]      r_last;
    logic [SW-1:0]      r_sum;
    logic               r_wr;
    logic [AW-1:0]      r_addr;
    logic [WIDTH_REG-1:0] r_data;

    logic               w_ready;
    logic               w_xfer;
    logic [SW-1:0]      w_sum_nx;

    assign w_xfer   = in_valid && w_ready;
    assign w_sum_nx = r_sum + SW'(in_data);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        cpu_run = 1'b0;
        done    = 1'b0;
        error   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
                if (w_xfer) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_ready = 1'b1;
                if (w_xfer && r_cnt == r_last) w_next = ST_CHECK;
            end
            ST_CHECK: begin
                w_ready = 1'b1;
                if (w_xfer) begin
                    w_next = (w_sum_nx == '0) ? ST_RUN : ST_ERROR;
                end
            end
            ST_RUN: begin
                cpu_run = 1'b1;
                done    = 1'b1;
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: w_next = ST_IDLE;
        endcase
        // Reload wins over any transfer in the same cycle.
        if (reload) w_next = ST_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_last <= '0;
            r_sum  <= '0;
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_data <= '0;
        end else begin
            r_wr <= 1'b0;
            if (reload) begin
                r_cnt <= '0;
                r_sum <= '0;
            end else if (w_xfer) begin
                if (r_state == ST_IDLE) begin
                    r_last <= in_data[AW-1:0];
                    r_sum  <= SW'(in_data);
                    r_cnt  <= '0;
                end else if (r_state == ST_LOAD) begin
                    r_wr   <= 1'b1;
                    r_addr <= r_cnt;
                    r_data <= in_data;
                    r_sum  <= w_sum_nx;
                    if (r_cnt != r_last) r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign in_ready = w_ready;
    assign mem_wr   = r_wr;
    assign mem_addr = r_addr;
    assign mem_data = r_data;

endmodule

// File: tb/tb_program_loader.sv
// Directed, table-driven bench for program_loader.
module tb_program_loader;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       reload;
    logic       mem_wr;
    logic [4:0] mem_addr;
    logic [7:0] mem_data;
    logic       cpu_run;
    logic       done;
    logic       error;

    int n_pass;
    int n_total;

    program_loader dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .reload   (reload),
        .mem_wr   (mem_wr),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .cpu_run  (cpu_run),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       rl;
        logic       wr;
        logic [4:0] a;
        logic [7:0] md;
        logic       rdy;
        logic       run;
        logic       dn;
        logic       err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic v, input logic [7:0] d, input logic rl,
        input logic wr, input logic [4:0] a, input logic [7:0] md,
        input logic rdy, input logic run, input logic dn, input logic err
    );
        vec_t t;
        t.v = v; t.d = d; t.rl = rl; t.wr = wr; t.a = a; t.md = md;
        t.rdy = rdy; t.run = run; t.dn = dn; t.err = err;
        return t;
    endfunction

    task automatic check(
        input string name, input logic wr, input logic [4:0] a,
        input logic [7:0] md, input logic rdy, input logic run,
        input logic dn, input logic err, input bit cmp_ad
    );
        bit ok;
        ok = (mem_wr === wr) && (in_ready === rdy) && (cpu_run === run)
          && (done === dn) && (error === err);
        if (wr || cmp_ad) ok = ok && (mem_addr === a) && (mem_data === md);
        n_total++;
        if (ok) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got wr=%b a=%h d=%h rdy=%b run=%b dn=%b err=%b want wr=%b a=%h d=%h rdy=%b run=%b dn=%b err=%b",
                     name, mem_wr, mem_addr, mem_data, in_ready, cpu_run,
                     done, error, wr, a, md, rdy, run, dn, err);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic rl);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        reload   = rl;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        reload   = 1'b0;
    endtask

    logic [7:0] thr_frame [5];

    initial begin
        n_pass   = 0;
        n_total  = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        reload   = 1'b0;

        // Good frame, full rate.
        tbl.push_back(mk(1, 8'h02, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA0, 0, 1, 0, 8'hA0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h21, 0, 1, 1, 8'h21, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hE0, 0, 1, 2, 8'hE0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h5D, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(1, 8'h77, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));
        // Bad checksum, then reload.
        tbl.push_back(mk(1, 8'h02, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA0, 0, 1, 0, 8'hA0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h21, 0, 1, 1, 8'h21, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hE0, 0, 1, 2, 8'hE0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h5C, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 8'h12, 0, 0, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));
        // Reload on second data byte; that byte is dropped.
        tbl.push_back(mk(1, 8'h02, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hA0, 0, 1, 0, 8'hA0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h21, 1, 0, 0, 0, 1, 0, 0, 0));
        // Fresh frame 02 11 22 33, C = 0x100 - 0x68 = 0x98.
        tbl.push_back(mk(1, 8'h02, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h11, 0, 1, 0, 8'h11, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h22, 0, 1, 1, 8'h22, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h33, 0, 1, 2, 8'h33, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h98, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));
        // Header upper bits ignored: E0 -> last=0, one data byte.
        // Sum E0 + 55 + CB = 0x200.
        tbl.push_back(mk(1, 8'hE0, 0, 0, 0, 0, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'h55, 0, 1, 0, 8'h55, 1, 0, 0, 0));
        tbl.push_back(mk(1, 8'hCB, 0, 0, 0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 0));

        #12;
        check("reset_hold", 0, 0, 0, 1, 0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", 0, 0, 0, 1, 0, 0, 0, 1);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d, tbl[i].rl);
            check($sformatf("vec%0d", i), tbl[i].wr, tbl[i].a, tbl[i].md,
                  tbl[i].rdy, tbl[i].run, tbl[i].dn, tbl[i].err, 0);
        end

        // Full depth: 32 bytes 00..1F, C = 0x100 - 0x20F[7:0] = 0xF1.
        step(1, 8'h1F, 0);
        check("full_hdr", 0, 0, 0, 1, 0, 0, 0, 0);
        for (int k = 0; k < 32; k++) begin
            step(1, 8'(k), 0);
            check($sformatf("full_wr%0d", k), 1, 5'(k), 8'(k), 1, 0, 0, 0, 0);
        end
        step(0, 8'h00, 0);
        check("full_chk_wait", 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 8'hF1, 0);
        check("full_done", 0, 0, 0, 0, 1, 1, 0, 0);
        step(0, 8'h00, 1);
        check("full_reload", 0, 0, 0, 1, 0, 0, 0, 0);

        // Throttled stream with random gaps.
        thr_frame[0] = 8'h02; thr_frame[1] = 8'hA0; thr_frame[2] = 8'h21;
        thr_frame[3] = 8'hE0; thr_frame[4] = 8'h5D;
        for (int k = 0; k < 5; k++) begin
            int gaps;
            gaps = $urandom_range(0, 3);
            for (int g = 0; g < gaps; g++) begin
                step(0, 8'($urandom), 0);
                check($sformatf("thr_gap%0d_%0d", k, g), 0, 0, 0, 1, 0, 0, 0, 0);
            end
            step(1, thr_frame[k], 0);
            if (k == 0 || k == 4) begin
                check($sformatf("thr_b%0d", k), 0, 0, 0, k != 4, k == 4,
                      k == 4, 0, 0);
            end else begin
                check($sformatf("thr_b%0d", k), 1, 5'(k - 1), thr_frame[k],
                      1, 0, 0, 0, 0);
            end
        end
        step(0, 8'h00, 1);
        check("thr_reload", 0, 0, 0, 1, 0, 0, 0, 0);

        // Async reset between edges mid-LOAD.
        step(1, 8'h02, 0);
        step(1, 8'hA0, 0);
        check("ar_pre", 1, 0, 8'hA0, 1, 0, 0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("ar_now", 0, 0, 0, 1, 0, 0, 0, 1);
        @(negedge clk);
        reset = 1'b1;
        step(1, 8'h02, 0);
        check("ar_hdr", 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, 8'hA0, 0);
        check("ar_d0", 1, 0, 8'hA0, 1, 0, 0, 0, 0);
        step(1, 8'h21, 0);
        step(1, 8'hE0, 0);
        step(1, 8'h5D, 0);
        check("ar_done", 0, 0, 0, 0, 1, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
